// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
// Holds forward-select encodings, stage shadow layout and FSM state codes.
package pipe_ctrl_pkg;

    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } stage_info_t;

    typedef logic [0:0] hz_state_e;

    localparam hz_state_e HZ_IDLE    = 1'b0;
    localparam hz_state_e HZ_MC_BUSY = 1'b1;

    // x0 is hardwired zero, so a write to it never produces a usable result.
    function automatic logic rd_hit(input logic                 valid,
                                    input logic                 wr,
                                    input logic [RF_ADDR_W-1:0] rd,
                                    input logic [RF_ADDR_W-1:0] rs);
        return valid && wr && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_select.sv
// Operand forward selector: picks EX/MEM ALU result, WB result or the regfile
// for one EX source register, using only the MEM and WB shadow state.
module hazard_fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RF_ADDRESS = RF_ADDR_W
) (
    input  logic [RF_ADDRESS-1:0] i_rs,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_regwrite,
    input  logic [RF_ADDRESS-1:0] i_mem_rd,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_regwrite,
    input  logic [RF_ADDRESS-1:0] i_wb_rd,
    output fwd_sel_e              o_sel
);

    // The younger MEM result wins when both stages write the same register.
    always_comb begin
        o_sel = FWD_RF;
        if (rd_hit(i_mem_valid, i_mem_regwrite, i_mem_rd, i_rs)) begin
            o_sel = FWD_MEM;
        end else if (rd_hit(i_wb_valid, i_wb_regwrite, i_wb_rd, i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32 pipeline: load-use stalls, redirect
// flushes, multi-cycle EX ops, operand forwarding and stall/flush perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RF_ADDRESS = RF_ADDR_W,
    parameter int unsigned MC_LAT_W   = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_id_valid,
    input  logic [RF_ADDRESS-1:0] i_id_rs1,
    input  logic [RF_ADDRESS-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic [RF_ADDRESS-1:0] i_id_rd,
    input  logic                  i_id_regwrite,
    input  logic                  i_id_memread,
    input  logic                  i_id_mc,
    input  logic [MC_LAT_W-1:0]   i_id_mc_lat,
    input  logic                  i_ex_pcsel,
    output logic                  o_pc_en,
    output logic                  o_if_id_en,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_en,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_bubble,
    output logic [1:0]            o_fwd_a_sel,
    output logic [1:0]            o_fwd_b_sel,
    output logic                  o_mc_busy,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    stage_info_t           r_ex;
    logic [RF_ADDRESS-1:0] r_ex_rs1;
    logic [RF_ADDRESS-1:0] r_ex_rs2;

    logic                  r_mem_valid;
    logic                  r_mem_regwrite;
    logic [RF_ADDRESS-1:0] r_mem_rd;

    logic                  r_wb_valid;
    logic                  r_wb_regwrite;
    logic [RF_ADDRESS-1:0] r_wb_rd;

    hz_state_e             r_state;
    logic [MC_LAT_W-1:0]   r_mc_cnt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic                  w_busy;
    logic                  w_load_use;
    logic                  w_redirect;
    logic                  w_mc_start;
    fwd_sel_e              w_fwd_a;
    fwd_sel_e              w_fwd_b;

    assign w_busy     = (r_state == HZ_MC_BUSY);
    assign w_redirect = i_ex_pcsel && !w_busy;

    assign w_load_use = r_ex.valid && r_ex.memread && (r_ex.rd != '0) &&
                        ((i_id_rs1_used && (r_ex.rd == i_id_rs1)) ||
                         (i_id_rs2_used && (r_ex.rd == i_id_rs2)));

    // Entry is decided as the op is loaded into EX so its very first EX cycle already stalls.
    assign w_mc_start = o_id_ex_en && !o_id_ex_flush && i_id_valid && i_id_mc &&
                        (i_id_mc_lat > MC_LAT_W'(1));

    always_comb begin
        o_pc_en         = 1'b1;
        o_if_id_en      = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_en      = 1'b1;
        o_id_ex_flush   = 1'b0;
        o_ex_mem_bubble = 1'b0;
        o_mc_busy       = 1'b0;
        if (reset) begin
            o_pc_en = 1'b1;
        end else if (w_busy) begin
            o_pc_en         = 1'b0;
            o_if_id_en      = 1'b0;
            o_id_ex_en      = 1'b0;
            o_ex_mem_bubble = 1'b1;
            o_mc_busy       = 1'b1;
        end else if (w_redirect) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
        end
    end

    hazard_fwd_select #(
        .RF_ADDRESS(RF_ADDRESS)
    ) u_fwd_a (
        .i_rs          (r_ex_rs1),
        .i_mem_valid   (r_mem_valid),
        .i_mem_regwrite(r_mem_regwrite),
        .i_mem_rd      (r_mem_rd),
        .i_wb_valid    (r_wb_valid),
        .i_wb_regwrite (r_wb_regwrite),
        .i_wb_rd       (r_wb_rd),
        .o_sel         (w_fwd_a)
    );

    hazard_fwd_select #(
        .RF_ADDRESS(RF_ADDRESS)
    ) u_fwd_b (
        .i_rs          (r_ex_rs2),
        .i_mem_valid   (r_mem_valid),
        .i_mem_regwrite(r_mem_regwrite),
        .i_mem_rd      (r_mem_rd),
        .i_wb_valid    (r_wb_valid),
        .i_wb_regwrite (r_wb_regwrite),
        .i_wb_rd       (r_wb_rd),
        .o_sel         (w_fwd_b)
    );

    assign o_fwd_a_sel = reset ? FWD_RF : w_fwd_a;
    assign o_fwd_b_sel = reset ? FWD_RF : w_fwd_b;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // Stage shadows; a flushed or bubbled slot is fully cleared so it can never match.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex           <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
        end else begin
            if (o_id_ex_en) begin
                if (o_id_ex_flush) begin
                    r_ex     <= '0;
                    r_ex_rs1 <= '0;
                    r_ex_rs2 <= '0;
                end else begin
                    r_ex.valid    <= i_id_valid;
                    r_ex.rd       <= i_id_rd;
                    r_ex.regwrite <= i_id_regwrite;
                    r_ex.memread  <= i_id_memread;
                    r_ex_rs1      <= i_id_rs1;
                    r_ex_rs2      <= i_id_rs2;
                end
            end
            if (o_ex_mem_bubble) begin
                r_mem_valid    <= 1'b0;
                r_mem_regwrite <= 1'b0;
                r_mem_rd       <= '0;
            end else begin
                r_mem_valid    <= r_ex.valid;
                r_mem_regwrite <= r_ex.regwrite;
                r_mem_rd       <= r_ex.rd;
            end
            r_wb_valid    <= r_mem_valid;
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_rd       <= r_mem_rd;
        end
    end

    // Busy lasts lat-1 cycles; the op leaves EX on the first idle cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= HZ_IDLE;
            r_mc_cnt <= '0;
        end else if (r_state == HZ_IDLE) begin
            if (w_mc_start) begin
                r_state  <= HZ_MC_BUSY;
                r_mc_cnt <= i_id_mc_lat - MC_LAT_W'(1);
            end
        end else if (r_mc_cnt <= MC_LAT_W'(1)) begin
            r_state  <= HZ_IDLE;
            r_mc_cnt <= '0;
        end else begin
            r_mc_cnt <= r_mc_cnt - MC_LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!o_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle expected control vectors are
// queued as each ID instruction is driven and compared when the cycle's outputs settle.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, id_mc, ex_pcsel;
    logic [4:0] id_rs1, id_rs2, id_rd, id_mc_lat;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, mc_busy;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_bubble;
    logic        s_mc_busy;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    typedef struct packed {
        logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble;
        logic [1:0] fwd_a, fwd_b;
        logic       mc_busy;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  val;
    } exp_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr, mc;
        logic [4:0] lat;
    } ins_t;

    localparam obs_t RUN   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam obs_t LU    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam obs_t BUSY  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1};
    localparam obs_t REDIR = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    pipeline_hazard_ctrl u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rs1_used  (id_rs1_used),
        .i_id_rs2_used  (id_rs2_used),
        .i_id_rd        (id_rd),
        .i_id_regwrite  (id_regwrite),
        .i_id_memread   (id_memread),
        .i_id_mc        (id_mc),
        .i_id_mc_lat    (id_mc_lat),
        .i_ex_pcsel     (ex_pcsel),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_en     (id_ex_en),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_bubble(ex_mem_bubble),
        .o_fwd_a_sel    (fwd_a_sel),
        .o_fwd_b_sel    (fwd_b_sel),
        .o_mc_busy      (mc_busy),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    // Narrow-counter copy, used only to observe saturation.
    pipeline_hazard_ctrl #(
        .CNT_W(2)
    ) u_dut_sat (
        .clk            (clk),
        .reset          (reset),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rs1_used  (id_rs1_used),
        .i_id_rs2_used  (id_rs2_used),
        .i_id_rd        (id_rd),
        .i_id_regwrite  (id_regwrite),
        .i_id_memread   (id_memread),
        .i_id_mc        (id_mc),
        .i_id_mc_lat    (id_mc_lat),
        .i_ex_pcsel     (ex_pcsel),
        .o_pc_en        (s_pc_en),
        .o_if_id_en     (s_if_id_en),
        .o_if_id_flush  (s_if_id_flush),
        .o_id_ex_en     (s_id_ex_en),
        .o_id_ex_flush  (s_id_ex_flush),
        .o_ex_mem_bubble(s_bubble),
        .o_fwd_a_sel    (s_fwd_a),
        .o_fwd_b_sel    (s_fwd_b),
        .o_mc_busy      (s_mc_busy),
        .o_stall_cnt    (s_stall_cnt),
        .o_flush_cnt    (s_flush_cnt)
    );

    always #5 clk = ~clk;

    // A redirect must never arrive while a multi-cycle op owns EX.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(mc_busy && ex_pcsel)) else begin
                errors++;
                $error("FAIL pcsel_during_busy: observed mc_busy=%b ex_pcsel=%b", mc_busy, ex_pcsel);
            end
        end
    end

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ins_t i = '0;
        i.valid = 1'b1;
        i.rs1   = rs1;
        i.rs2   = rs2;
        i.u1    = 1'b1;
        i.u2    = 1'b1;
        i.rd    = rd;
        i.rw    = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        ins_t i = '0;
        i.valid = 1'b1;
        i.rs1   = rs1;
        i.u1    = 1'b1;
        i.rd    = rd;
        i.rw    = 1'b1;
        i.mr    = 1'b1;
        return i;
    endfunction

    function automatic ins_t mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] lat);
        ins_t i = alu(rd, rs1, rs2);
        i.mc  = 1'b1;
        i.lat = lat;
        return i;
    endfunction

    function automatic obs_t fw(input obs_t base, input logic [1:0] a, input logic [1:0] b);
        obs_t o = base;
        o.fwd_a = a;
        o.fwd_b = b;
        return o;
    endfunction

    task automatic drive(input ins_t i, input logic pcsel);
        id_valid    = i.valid;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_rs1_used = i.u1;
        id_rs2_used = i.u2;
        id_rd       = i.rd;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        id_mc       = i.mc;
        id_mc_lat   = i.lat;
        ex_pcsel    = pcsel;
    endtask

    task automatic compare_out();
        exp_t x;
        obs_t o;
        x = sb_q.pop_front();
        o = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble,
             fwd_a_sel, fwd_b_sel, mc_busy};
        checks++;
        assert (o === x.val) else begin
            errors++;
            $error("FAIL %s: observed pc/ifen/iff/idexen/idexf/bub/fa/fb/busy=%b expected %b",
                   x.tag, o, x.val);
        end
    endtask

    // One pipeline cycle: drive ID, queue the expected controls, check mid-cycle.
    task automatic step(input string tag, input ins_t i, input logic pcsel, input obs_t e);
        exp_t x;
        drive(i, pcsel);
        x.tag = tag;
        x.val = e;
        sb_q.push_back(x);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        int sat;
        sat = (exp_stall > 3) ? 3 : exp_stall;
        checks++;
        assert (stall_cnt === 32'(exp_stall)) else begin
            errors++;
            $error("FAIL %s_stall_cnt: observed %0d expected %0d", tag, stall_cnt, exp_stall);
        end
        checks++;
        assert (flush_cnt === 32'(exp_flush)) else begin
            errors++;
            $error("FAIL %s_flush_cnt: observed %0d expected %0d", tag, flush_cnt, exp_flush);
        end
        checks++;
        assert (s_stall_cnt === 2'(sat)) else begin
            errors++;
            $error("FAIL %s_sat_stall_cnt: observed %0d expected %0d", tag, s_stall_cnt, sat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(nop(), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset_outputs", nop(), 1'b0, RUN);
        reset = 1'b0;
        chk_cnt("after_reset");
        for (int k = 0; k < 5; k++) step("idle", nop(), 1'b0, RUN);
        chk_cnt("idle");

        // lw x5 ; add x6,x5,x7
        step("lu_lw", lw(5'd5, 5'd1), 1'b0, RUN);
        step("lu_stall", alu(5'd6, 5'd5, 5'd7), 1'b0, LU);
        step("lu_bubble", alu(5'd6, 5'd5, 5'd7), 1'b0, RUN);
        step("lu_fwd_wb", nop(), 1'b0, fw(RUN, 2'b01, 2'b00));
        exp_stall = 1;
        chk_cnt("load_use");
        for (int k = 0; k < 3; k++) step("drain1", nop(), 1'b0, RUN);

        // add x5 ; sub x5 ; or x8,x5,x5
        step("fwd_add", alu(5'd5, 5'd1, 5'd2), 1'b0, RUN);
        step("fwd_sub", alu(5'd5, 5'd3, 5'd4), 1'b0, RUN);
        step("fwd_or", alu(5'd8, 5'd5, 5'd5), 1'b0, RUN);
        step("fwd_mem_wins", nop(), 1'b0, fw(RUN, 2'b10, 2'b10));
        step("fwd_gone", nop(), 1'b0, RUN);

        // Same sequence targeting x0
        step("x0_add", alu(5'd0, 5'd1, 5'd2), 1'b0, RUN);
        step("x0_sub", alu(5'd0, 5'd3, 5'd4), 1'b0, RUN);
        step("x0_or", alu(5'd8, 5'd0, 5'd0), 1'b0, RUN);
        step("x0_no_fwd", nop(), 1'b0, RUN);
        for (int k = 0; k < 3; k++) step("drain2", nop(), 1'b0, RUN);

        // mul lat=4 followed by a dependent add
        step("mul4_issue", mul(5'd9, 5'd1, 5'd2, 5'd4), 1'b0, RUN);
        for (int k = 0; k < 3; k++) step("mul4_busy", alu(5'd10, 5'd9, 5'd3), 1'b0, BUSY);
        step("mul4_release", alu(5'd10, 5'd9, 5'd3), 1'b0, RUN);
        step("mul4_fwd_mem", nop(), 1'b0, fw(RUN, 2'b10, 2'b00));
        exp_stall = 4;
        chk_cnt("mul4");

        // lat=1 is single-cycle, lat=2 is the shortest stalling op
        step("mul1_issue", mul(5'd11, 5'd1, 5'd2, 5'd1), 1'b0, RUN);
        step("mul1_ex", nop(), 1'b0, RUN);
        step("mul1_mem", nop(), 1'b0, RUN);
        chk_cnt("mul1");
        step("mul2_issue", mul(5'd12, 5'd1, 5'd2, 5'd2), 1'b0, RUN);
        step("mul2_busy", nop(), 1'b0, BUSY);
        step("mul2_release", nop(), 1'b0, RUN);
        step("mul2_after", nop(), 1'b0, RUN);
        exp_stall = 5;
        chk_cnt("mul2");

        // Load-use coinciding with a redirect: flush only
        step("redir_lw", lw(5'd5, 5'd1), 1'b0, RUN);
        step("redir_lu", alu(5'd6, 5'd5, 5'd7), 1'b1, REDIR);
        step("redir_after", nop(), 1'b0, RUN);
        exp_flush = 1;
        chk_cnt("redirect");

        // Reset during a lat=8 op
        step("mul8_issue", mul(5'd13, 5'd1, 5'd2, 5'd8), 1'b0, RUN);
        step("mul8_busy", nop(), 1'b0, BUSY);
        reset = 1'b1;
        step("mul8_reset", nop(), 1'b0, RUN);
        reset = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        chk_cnt("mid_mc_reset");
        step("post_reset0", nop(), 1'b0, RUN);
        step("post_reset1", nop(), 1'b0, RUN);
        chk_cnt("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
